// File: rtl/myhardware_led_seq.sv
// LED pattern sequencer: a register slave holds up to four 10-bit patterns
// and a step period; the FSM writes each pattern to an LED PIO over a
// simple master port, dwelling PERIOD cycles per step.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   s_address..       control slave (word address, chipselect, write_n,
//   s_readdata        writedata); readdata is combinational from s_address
//   m_address..       LED PIO master (address fixed 0, chipselect, write_n,
//   m_waitrequest     writedata = {22'b0, pattern}, waitrequest stall)
//   irq               only with MYHARDWARE_LED_SEQ_IRQ_EN: DONE & CTRL.IRQ_EN
//
// Register map: 0 CTRL (RUN, ONESHOT, IRQ_EN), 1 PERIOD,
// 2 STATUS (BUSY, IDX[3:2], DONE; any write clears DONE), 4..7 PAT0..PAT3.
module myhardware_led_seq #(
    parameter int NUM_PAT  = 4,
    parameter int PERIOD_W = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
`ifdef MYHARDWARE_LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DWELL
    } state_t;

    state_t              state;
    logic                run;
    logic                oneshot;
    logic                irq_en;
    logic [PERIOD_W-1:0] period;
    logic [9:0]          pat [NUM_PAT];
    logic [1:0]          idx;
    logic                done;
    logic [PERIOD_W-1:0] cnt;

    logic                wr_en;
    logic                busy;
    logic [PERIOD_W-1:0] eff_period;
    logic                last_step;
    logic                advance;
    logic [1:0]          nxt_idx;
    logic                unused_wdata;

    assign m_address    = 2'b00;
    assign unused_wdata = ^s_writedata;

    always_comb begin
        wr_en      = s_chipselect & ~s_write_n;
        busy       = (state != IDLE);
        eff_period = (period == '0) ? PERIOD_W'(1) : period;
        last_step  = oneshot && (idx == 2'(NUM_PAT - 1));
        nxt_idx    = idx + 2'd1;
        // The accepted write cycle is the first cycle of the step, so a
        // one-cycle period advances straight from WRITE; otherwise DWELL
        // runs the remaining period-1 cycles.
        advance    = 1'b0;
        if (run) begin
            if (state == WRITE && !m_waitrequest && eff_period == PERIOD_W'(1))
                advance = 1'b1;
            if (state == DWELL && cnt <= PERIOD_W'(1))
                advance = 1'b1;
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            3'd0:    s_readdata = {29'b0, irq_en, oneshot, run};
            3'd1:    s_readdata = 32'(period);
            3'd2:    s_readdata = {27'b0, done, idx, 1'b0, busy};
            3'd4,
            3'd5,
            3'd6,
            3'd7:    s_readdata = {22'b0, pat[s_address[1:0]]};
            default: s_readdata = '0;
        endcase
    end

`ifdef MYHARDWARE_LED_SEQ_IRQ_EN
    assign irq = done & irq_en;
`else
    assign irq_en = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            run          <= 1'b0;
            oneshot      <= 1'b0;
`ifdef MYHARDWARE_LED_SEQ_IRQ_EN
            irq_en       <= 1'b0;
`endif
            period       <= '0;
            for (int i = 0; i < NUM_PAT; i++)
                pat[i] <= '0;
            idx          <= '0;
            done         <= 1'b0;
            cnt          <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
        end else begin
            if (wr_en) begin
                case (s_address)
                    3'd1:    period <= s_writedata[PERIOD_W-1:0];
                    3'd2:    done <= 1'b0;
                    3'd4,
                    3'd5,
                    3'd6,
                    3'd7:    pat[s_address[1:0]] <= s_writedata[9:0];
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (run) begin
                        idx          <= '0;
                        state        <= WRITE;
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_writedata  <= {22'b0, pat[0]};
                    end
                end
                WRITE: begin
                    if (!m_waitrequest) begin
                        m_chipselect <= 1'b0;
                        m_write_n    <= 1'b1;
                        m_writedata  <= '0;
                        if (!run) begin
                            state <= IDLE;
                        end else if (!advance) begin
                            cnt   <= eff_period - PERIOD_W'(1);
                            state <= DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (!run)
                        state <= IDLE;
                    else if (!advance)
                        cnt <= cnt - PERIOD_W'(1);
                end
                default: state <= IDLE;
            endcase

            // Step boundary: finish a oneshot run or move to the next slot.
            if (advance) begin
                cnt <= '0;
                if (last_step) begin
                    run   <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end else begin
                    idx          <= nxt_idx;
                    state        <= WRITE;
                    m_chipselect <= 1'b1;
                    m_write_n    <= 1'b0;
                    m_writedata  <= {22'b0, pat[nxt_idx]};
                end
            end

            // Placed last so a software CTRL write beats the FSM clearing RUN.
            if (wr_en && s_address == 3'd0) begin
                run     <= s_writedata[0];
                oneshot <= s_writedata[1];
`ifdef MYHARDWARE_LED_SEQ_IRQ_EN
                irq_en  <= s_writedata[2];
`endif
            end
        end
    end

endmodule

// File: tb/tb_myhardware_led_seq.sv
// Self-checking bench for myhardware_led_seq: register map table plus
// directed multi-cycle sequences (free run, oneshot, stall, stop, reset).
module tb_myhardware_led_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  s_address = '0;
    logic        s_chipselect = 1'b0;
    logic        s_write_n = 1'b1;
    logic [31:0] s_writedata = '0;
    logic [31:0] s_readdata;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic        m_waitrequest = 1'b0;
`ifdef MYHARDWARE_LED_SEQ_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL_EXP = 32'h4;
`else
    localparam logic [31:0] CTRL_EXP = 32'h0;
`endif

    myhardware_led_seq dut (
        .clk          (clk),
        .reset        (reset),
        .s_address    (s_address),
        .s_chipselect (s_chipselect),
        .s_write_n    (s_write_n),
        .s_writedata  (s_writedata),
        .s_readdata   (s_readdata),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_waitrequest(m_waitrequest)
`ifdef MYHARDWARE_LED_SEQ_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wcyc[$];
    logic [31:0] wdat[$];

    // Record every accepted PIO write with its edge number.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_chipselect === 1'b1 && m_write_n === 1'b0 && m_waitrequest === 1'b0) begin
            wcyc.push_back(cyc);
            wdat.push_back(m_writedata);
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vt[12];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        s_address    = a;
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(posedge clk);
        #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        s_address = a;
        #1;
        chk(nm, s_readdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic setup(input logic [31:0] p);
        wr(3'd4, 32'h001);
        wr(3'd5, 32'h002);
        wr(3'd6, 32'h004);
        wr(3'd7, 32'h008);
        wr(3'd1, p);
        wcyc.delete();
        wdat.delete();
    endtask

    task automatic wait_writes(input int n, input int budget, input string nm);
        int k = 0;
        while (wcyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk(nm, 32'(wcyc.size() >= n), 32'd1);
    endtask

    task automatic chk_run(input string nm, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (wcyc.size() > i) begin
                chk({nm, "_data"}, wdat[i], 32'd1 << (i % 4));
                if (i > 0)
                    chk({nm, "_gap"}, 32'(wcyc[i] - wcyc[i-1]), 32'(gap));
            end
        end
    endtask

    int t0;

    initial begin
        vt[0]  = '{1'b0, 3'd0, 32'h0,        32'h0,        "rst_ctrl"};
        vt[1]  = '{1'b0, 3'd1, 32'h0,        32'h0,        "rst_period"};
        vt[2]  = '{1'b0, 3'd2, 32'h0,        32'h0,        "rst_status"};
        vt[3]  = '{1'b0, 3'd4, 32'h0,        32'h0,        "rst_pat0"};
        vt[4]  = '{1'b1, 3'd1, 32'hFFABCDEF, 32'h00ABCDEF, "period_w"};
        vt[5]  = '{1'b1, 3'd4, 32'hFFFFFFFF, 32'h000003FF, "pat0_w"};
        vt[6]  = '{1'b1, 3'd5, 32'h00000155, 32'h00000155, "pat1_w"};
        vt[7]  = '{1'b1, 3'd3, 32'h12345678, 32'h0,        "addr3_ign"};
        vt[8]  = '{1'b1, 3'd0, 32'hFFFFFFFC, CTRL_EXP,     "ctrl_hibits"};
        vt[9]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'h0,        "status_w"};
        vt[10] = '{1'b1, 3'd7, 32'h00000200, 32'h00000200, "pat3_w"};
        vt[11] = '{1'b0, 3'd6, 32'h0,        32'h0,        "pat2_rd"};

        do_reset();
        chk("rst_m_cs", 32'(m_chipselect), 32'd0);
        chk("rst_m_wn", 32'(m_write_n), 32'd1);
        chk("rst_m_wd", m_writedata, 32'd0);
        chk("m_addr", 32'(m_address), 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (vt[i].we)
                wr(vt[i].a, vt[i].d);
            rd_chk(vt[i].nm, vt[i].a, vt[i].exp);
        end

        // Free-running sequence, period 3.
        do_reset();
        setup(32'd3);
        wr(3'd0, 32'd1);
        t0 = cyc;
        wait_writes(6, 40, "run_wait");
        if (wcyc.size() > 0)
            chk("run_latency", 32'(wcyc[0] - t0), 32'd2);
        chk_run("run", 6, 3);
        rd_chk("run_busy", 3'd2, {27'b0, dut.done, dut.idx, 2'b01});
        wr(3'd0, 32'd0);
        tick(2);
        rd_chk("stop_ctrl", 3'd0, 32'd0);
        s_address = 3'd2;
        #1;
        chk("stop_busy", s_readdata & 32'h1, 32'd0);

        // Oneshot: exactly four writes then DONE.
        do_reset();
        setup(32'd3);
        wr(3'd0, 32'd3);
        tick(30);
        chk("os_count", 32'(wcyc.size()), 32'd4);
        chk_run("os", 4, 3);
        rd_chk("os_status", 3'd2, 32'h1C);
        rd_chk("os_ctrl", 3'd0, 32'h2);
        wr(3'd2, 32'd0);
        rd_chk("os_clr", 3'd2, 32'h0C);

        // Stall the first write for five cycles.
        do_reset();
        setup(32'd3);
        m_waitrequest = 1'b1;
        wr(3'd0, 32'd1);
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("stall_cs", 32'(m_chipselect), 32'd1);
            chk("stall_wn", 32'(m_write_n), 32'd0);
            chk("stall_wd", m_writedata, 32'h001);
        end
        chk("stall_nowr", 32'(wcyc.size()), 32'd0);
        m_waitrequest = 1'b0;
        wait_writes(2, 20, "stall_wait");
        if (wcyc.size() > 1) begin
            chk("stall_acc", 32'(wcyc[0] - t0), 32'd6);
            chk("stall_next", 32'(wcyc[1] - t0), 32'd9);
            chk("stall_data", wdat[1], 32'h002);
        end
        wr(3'd0, 32'd0);

        // Stop during DWELL at IDX=2.
        do_reset();
        setup(32'd3);
        wr(3'd0, 32'd1);
        wait_writes(3, 30, "stop_wait");
        wr(3'd0, 32'd0);
        tick(1);
        rd_chk("dwell_stop", 3'd2, 32'h08);
        tick(10);
        chk("dwell_nowr", 32'(wcyc.size()), 32'd3);

        // PERIOD=0 writes every cycle.
        do_reset();
        setup(32'd0);
        wr(3'd0, 32'd1);
        wait_writes(6, 20, "p0_wait");
        chk_run("p0", 6, 1);
        wr(3'd0, 32'd0);
        tick(3);

        // Reset in the middle of a stalled write.
        do_reset();
        setup(32'd3);
        m_waitrequest = 1'b1;
        wr(3'd0, 32'd1);
        tick(1);
        chk("rw_cs_pre", 32'(m_chipselect), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("rw_cs", 32'(m_chipselect), 32'd0);
        chk("rw_wn", 32'(m_write_n), 32'd1);
        chk("rw_wd", m_writedata, 32'd0);
        for (int a = 0; a < 8; a++)
            rd_chk("rw_reg", 3'(a), 32'd0);
        reset = 1'b0;
        m_waitrequest = 1'b0;
        wcyc.delete();
        wdat.delete();
        tick(10);
        chk("rw_nowr", 32'(wcyc.size()), 32'd0);

`ifdef MYHARDWARE_LED_SEQ_IRQ_EN
        do_reset();
        chk("irq_rst", 32'(irq), 32'd0);
        setup(32'd3);
        wr(3'd0, 32'd7);
        tick(30);
        chk("irq_set", 32'(irq), 32'd1);
        rd_chk("irq_ctrl", 3'd0, 32'h6);
        wr(3'd2, 32'd0);
        chk("irq_clr", 32'(irq), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
